// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised multi-port register file.
// The clear-engine state encoding and the byte-lane merge used by writes and bypass live here.
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    // Widest word lane_merge handles; callers zero-extend narrower words and truncate the result.
    localparam int unsigned MAX_DATA_W = 256;
    localparam int unsigned MAX_LANES  = MAX_DATA_W / 8;

    function automatic logic [MAX_DATA_W-1:0] lane_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_LANES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_word;
        for (int k = 0; k < int'(MAX_LANES); k++) begin
            if (be[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Sequenced clear engine: walks every entry once, zeroing one per cycle, and flags busy meanwhile.
// Drives the storage write port directly through clr_we/clr_addr while the sweep runs.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;

    // Next-state: a request only starts a sweep from IDLE; the sweep ends after the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // State register; reset always (re)starts a full sweep at entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_multi.sv
// Parametrised 2-read/1-write register file with byte-lane writes, optional write-first bypass,
// optional registered reads, optional hardwired-zero entry 0 and a one-entry-per-cycle clear sweep.
module regfile_multi
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int REG_READ = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr_wr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [ADDR_W-1:0]     addr_rd1,
    input  logic [ADDR_W-1:0]     addr_rd2,
    output logic [DATA_W-1:0]     data_out1,
    output logic [DATA_W-1:0]     data_out2
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LANES = DATA_W / 8;

    logic              busy_s;
    logic              clr_we_s;
    logic [ADDR_W-1:0] clr_addr_s;

    regfile_clear_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .busy     (busy_s),
        .clr_we   (clr_we_s),
        .clr_addr (clr_addr_s)
    );

    assign busy = busy_s;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              zero_wr_s;
    logic              wr_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_data_s;
    logic [LANES-1:0]  mem_be_s;

    // External writes are dropped outright while the sweep owns the port.
    assign zero_wr_s = (ZERO_R0 != 0) && (addr_wr == {ADDR_W{1'b0}});
    assign wr_en_s   = we && !busy_s && (|be) && !zero_wr_s;

    // Write-port mux: the clear engine has priority over the writeback stage.
    always_comb begin
        mem_we_s   = 1'b0;
        mem_addr_s = addr_wr;
        mem_data_s = data_in;
        mem_be_s   = be;
        if (clr_we_s) begin
            mem_we_s   = 1'b1;
            mem_addr_s = clr_addr_s;
            mem_data_s = {DATA_W{1'b0}};
            mem_be_s   = {LANES{1'b1}};
        end else begin
            mem_we_s   = wr_en_s;
            mem_addr_s = addr_wr;
            mem_data_s = data_in;
            mem_be_s   = be;
        end
    end

    // Storage: no reset so it maps onto RAM; the sweep provides the zeroing.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int k = 0; k < LANES; k++) begin
                if (mem_be_s[k]) begin
                    mem_q[mem_addr_s][8*k +: 8] <= mem_data_s[8*k +: 8];
                end
            end
        end
    end

    logic [1:0][ADDR_W-1:0] rd_addr_s;
    logic [1:0][DATA_W-1:0] stored_s;
    logic [1:0][DATA_W-1:0] merged_s;
    logic [1:0][DATA_W-1:0] rd_s;

    assign rd_addr_s[0] = addr_rd1;
    assign rd_addr_s[1] = addr_rd2;

    // Read resolution per port: busy blanking, then hardwired zero, then write-first bypass.
    always_comb begin
        stored_s = {2*DATA_W{1'b0}};
        merged_s = {2*DATA_W{1'b0}};
        rd_s     = {2*DATA_W{1'b0}};
        for (int p = 0; p < 2; p++) begin
            stored_s[p] = mem_q[rd_addr_s[p]];
            merged_s[p] = DATA_W'(lane_merge(MAX_DATA_W'(stored_s[p]),
                                             MAX_DATA_W'(data_in),
                                             MAX_LANES'(be)));
            if (busy_s) begin
                rd_s[p] = {DATA_W{1'b0}};
            end else if ((ZERO_R0 != 0) && (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
                rd_s[p] = {DATA_W{1'b0}};
            end else if ((BYPASS != 0) && wr_en_s && (addr_wr == rd_addr_s[p])) begin
                rd_s[p] = merged_s[p];
            end else begin
                rd_s[p] = stored_s[p];
            end
        end
    end

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [DATA_W-1:0] data_out1_q;
            logic [DATA_W-1:0] data_out2_q;

            // Registered read ports: capture the resolved value at the same edge as any write.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_out1_q <= {DATA_W{1'b0}};
                    data_out2_q <= {DATA_W{1'b0}};
                end else begin
                    data_out1_q <= rd_s[0];
                    data_out2_q <= rd_s[1];
                end
            end

            assign data_out1 = data_out1_q;
            assign data_out2 = data_out2_q;
        end else begin : g_comb_read
            assign data_out1 = rd_s[0];
            assign data_out2 = rd_s[1];
        end
    endgenerate

endmodule
